id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus load-use hazard detection for the 5-stage RV32I core.

---
 rtl/id_ex_stage_pkg.sv | 33 +++
 rtl/id_ex_stage_hazard_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register:
//   - bit positions inside the 8-bit decoded control word
//   - ALU operation-class encodings
//   - helper that builds the all-zero bubble control word
// ----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int CTRL_W = 8;

    // Control word layout: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,alu_op[1:0]}
    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,   // loads/stores: address add
        ALU_OP_SUB   = 2'b01,   // branches: compare via subtract
        ALU_OP_FUNCT = 2'b10    // R/I-type: decoded from funct3/funct7
    } alu_op_e;

    // A bubble carries no side effects: every control bit is cleared.
    function automatic logic [CTRL_W-1:0] bubble_ctrl();
        return '0;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector. Flags when the instruction now in EX is a
// load writing a non-x0 register that the valid instruction in ID reads.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rd_addr_i   - state of the EX-stage instruction
//   id_valid_i, id_rs1_addr_i, id_rs2_addr_i  - sources of the ID-stage instruction
//   haz_o                                     - load-use hazard present
// ----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    output logic              haz_o
);

    logic rd_nonzero;
    logic src_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rd_nonzero = (ex_rd_addr_i != '0);
    assign src_match  = (ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i);
    assign haz_o      = ex_valid_i & ex_mem_read_i & rd_nonzero & id_valid_i & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection for the 5-stage
// RV32I core. Captures decoded operands, immediate and control at the end of
// ID; inserts one bubble per load-use hazard and raises stall_o so PC and
// IF/ID hold the dependent instruction for a cycle.
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_*      : decoded instruction fields from ID
//   hold_i    : global freeze, register keeps contents
//   flush_i   : squash ID instruction (branch taken in EX)
//   ex_*      : registered copies presented to EX
//   stall_o   : load-use hazard, freeze PC and IF/ID this cycle
//   bubble_cnt_o : saturating count of inserted bubbles
// Edge priority: flush > hold > hazard > load.
// ----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs1_addr_o,
    output logic [REG_AW-1:0] ex_rs2_addr_o,
    output logic [REG_AW-1:0] ex_rd_addr_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              ex_alu_src_o,
    output logic              ex_branch_o,
    output logic [1:0]        ex_alu_op_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic              haz;
    logic              insert_bubble;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .ex_valid_i    (ex_valid_o),
        .ex_mem_read_i (ex_mem_read_o),
        .ex_rd_addr_i  (ex_rd_addr_o),
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .haz_o         (haz)
    );

    // A flush already discards the ID instruction, so there is nothing to stall for.
    assign stall_o = haz & ~flush_i;

    // Bubble on flush, or on a hazard when not frozen by hold.
    assign insert_bubble = flush_i | (~hold_i & haz);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_addr_o <= '0;
            ex_rs2_addr_o <= '0;
            ex_rd_addr_o  <= '0;
            ctrl_q        <= '0;
        end else if (insert_bubble) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_addr_o <= '0;
            ex_rs2_addr_o <= '0;
            ex_rd_addr_o  <= '0;
            ctrl_q        <= bubble_ctrl();
        end else if (!hold_i) begin
            ex_valid_o    <= id_valid_i;
            ex_pc_o       <= id_pc_i;
            ex_rs1_data_o <= id_rs1_data_i;
            ex_rs2_data_o <= id_rs2_data_i;
            ex_imm_o      <= id_imm_i;
            ex_rs1_addr_o <= id_rs1_addr_i;
            ex_rs2_addr_o <= id_rs2_addr_i;
            ex_rd_addr_o  <= id_rd_addr_i;
            ctrl_q        <= id_ctrl_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            bubble_cnt_o <= '0;
        else if (insert_bubble && (bubble_cnt_o != '1))
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end

    assign ex_reg_write_o  = ctrl_q[CTRL_REG_WRITE];
    assign ex_mem_read_o   = ctrl_q[CTRL_MEM_READ];
    assign ex_mem_write_o  = ctrl_q[CTRL_MEM_WRITE];
    assign ex_mem_to_reg_o = ctrl_q[CTRL_MEM_TO_REG];
    assign ex_alu_src_o    = ctrl_q[CTRL_ALU_SRC];
    assign ex_branch_o     = ctrl_q[CTRL_BRANCH];
    assign ex_alu_op_o     = ctrl_q[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO];

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: reset, pass-through, load-use bubble,
// x0 exemption, flush-vs-hazard priority, hold freeze, async reset mid-stall
// and bubble-counter saturation.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    // Control words: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,alu_op}
    localparam logic [7:0] C_LW   = 8'hD8;  // reg_write,mem_read,mem_to_reg,alu_src
    localparam logic [7:0] C_ADD  = 8'h82;  // reg_write, alu_op=10
    localparam logic [7:0] C_ADDI = 8'h8A;  // reg_write, alu_src, alu_op=10

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              id_valid_i;
    logic [DATA_W-1:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [REG_AW-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic [7:0]        id_ctrl_i;
    logic              hold_i, flush_i;
    logic              ex_valid_o;
    logic [DATA_W-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [REG_AW-1:0] ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
    logic              ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
    logic              ex_alu_src_o, ex_branch_o;
    logic [1:0]        ex_alu_op_o;
    logic              stall_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_ctrl_i(id_ctrl_i), .hold_i(hold_i), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
        .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rs1_addr_o(ex_rs1_addr_o),
        .ex_rs2_addr_o(ex_rs2_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .ex_alu_src_o(ex_alu_src_o), .ex_branch_o(ex_branch_o), .ex_alu_op_o(ex_alu_op_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it before sampling/driving.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl,
                            input logic [31:0] imm);
        id_valid_i    = v;
        id_pc_i       = pc;
        id_rs1_addr_i = rs1;
        id_rs2_addr_i = rs2;
        id_rd_addr_i  = rd;
        id_ctrl_i     = ctrl;
        id_imm_i      = imm;
        id_rs1_data_i = pc ^ 32'h1111_0000;
        id_rs2_data_i = pc ^ 32'h0000_2222;
    endtask

    initial begin
        rst_i = 1'b1;
        hold_i = 1'b0;
        flush_i = 1'b0;
        drive_id(1'b1, 32'h0000_0010, 5'd3, 5'd4, 5'd9, C_ADD, 32'h5);
        step();
        step();
        // Reset asserted mid-cycle: outputs must clear without a clock edge
        #2 rst_i = 1'b0;
        #1;
        check("rst_valid", 32'(ex_valid_o), 32'd0);
        check("rst_pc", ex_pc_o, 32'd0);
        check("rst_rd", 32'(ex_rd_addr_o), 32'd0);
        check("rst_ctrl", {25'd0, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
                           ex_alu_src_o, ex_branch_o, ex_alu_op_o}, 32'd0);
        check("rst_cnt", 32'(bubble_cnt_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        step();
        rst_i = 1'b1;

        // Pass-through of an addi
        drive_id(1'b1, 32'h40, 5'd2, 5'd3, 5'd8, C_ADDI, 32'h10);
        step();
        check("pt_valid", 32'(ex_valid_o), 32'd1);
        check("pt_pc", ex_pc_o, 32'h40);
        check("pt_imm", ex_imm_o, 32'h10);
        check("pt_alu_src", 32'(ex_alu_src_o), 32'd1);
        check("pt_rs2_data", ex_rs2_data_o, 32'h40 ^ 32'h0000_2222);
        check("pt_alu_op", 32'(ex_alu_op_o), 32'd2);
        check("pt_stall", 32'(stall_o), 32'd0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        drive_id(1'b1, 32'h44, 5'd2, 5'd0, 5'd5, C_LW, 32'h8);
        step();
        check("lu_lw_memrd", 32'(ex_mem_read_o), 32'd1);
        drive_id(1'b1, 32'h48, 5'd5, 5'd1, 5'd6, C_ADD, 32'h0);
        #1;
        check("lu_stall", 32'(stall_o), 32'd1);
        step();
        check("lu_bub_valid", 32'(ex_valid_o), 32'd0);
        check("lu_bub_pc", ex_pc_o, 32'd0);
        check("lu_bub_regwr", 32'(ex_reg_write_o), 32'd0);
        check("lu_cnt", 32'(bubble_cnt_o), 32'd1);
        check("lu_stall_drop", 32'(stall_o), 32'd0);
        step();
        check("lu_add_valid", 32'(ex_valid_o), 32'd1);
        check("lu_add_pc", ex_pc_o, 32'h48);
        check("lu_add_rd", 32'(ex_rd_addr_o), 32'd6);

        // Load to x0 never stalls
        drive_id(1'b1, 32'h4C, 5'd2, 5'd0, 5'd0, C_LW, 32'h0);
        step();
        drive_id(1'b1, 32'h50, 5'd0, 5'd0, 5'd7, C_ADD, 32'h0);
        #1;
        check("x0_stall", 32'(stall_o), 32'd0);
        step();
        check("x0_pc", ex_pc_o, 32'h50);
        check("x0_cnt", 32'(bubble_cnt_o), 32'd1);

        // Flush and hazard together: no stall, a single bubble
        drive_id(1'b1, 32'h54, 5'd2, 5'd0, 5'd5, C_LW, 32'h0);
        step();
        drive_id(1'b1, 32'h58, 5'd1, 5'd5, 5'd6, C_ADD, 32'h0);
        flush_i = 1'b1;
        #1;
        check("fl_stall", 32'(stall_o), 32'd0);
        step();
        flush_i = 1'b0;
        check("fl_valid", 32'(ex_valid_o), 32'd0);
        check("fl_cnt", 32'(bubble_cnt_o), 32'd2);
        step();
        check("fl_next_pc", ex_pc_o, 32'h58);
        check("fl_next_cnt", 32'(bubble_cnt_o), 32'd2);

        // Hold with a pending load-use: frozen, stall persists, no counting
        drive_id(1'b1, 32'h5C, 5'd2, 5'd0, 5'd5, C_LW, 32'h0);
        step();
        drive_id(1'b1, 32'h60, 5'd5, 5'd5, 5'd6, C_ADD, 32'h0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc", ex_pc_o, 32'h5C);
            check("hold_stall", 32'(stall_o), 32'd1);
            check("hold_cnt", 32'(bubble_cnt_o), 32'd2);
        end
        hold_i = 1'b0;
        step();
        check("hold_rel_valid", 32'(ex_valid_o), 32'd0);
        check("hold_rel_cnt", 32'(bubble_cnt_o), 32'd3);
        step();
        check("hold_rel_pc", ex_pc_o, 32'h60);

        // Reset in the middle of a stall
        drive_id(1'b1, 32'h64, 5'd2, 5'd0, 5'd5, C_LW, 32'h0);
        step();
        drive_id(1'b1, 32'h68, 5'd5, 5'd1, 5'd6, C_ADD, 32'h0);
        #1;
        check("rs_stall_pre", 32'(stall_o), 32'd1);
        #1 rst_i = 1'b0;
        #1;
        check("rs_stall", 32'(stall_o), 32'd0);
        check("rs_valid", 32'(ex_valid_o), 32'd0);
        check("rs_cnt", 32'(bubble_cnt_o), 32'd0);
        step();
        rst_i = 1'b1;

        // Saturation: drive the counter to all-ones with continuous flushes
        flush_i = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk_i);
        #1;
        check("sat_fffe", 32'(bubble_cnt_o), 32'hFFFE);
        step();
        check("sat_ffff", 32'(bubble_cnt_o), 32'hFFFF);
        step();
        step();
        check("sat_hold", 32'(bubble_cnt_o), 32'hFFFF);
        flush_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
